tcp_tx_arbiter: RTL and testbench

Round-robin packet scheduler that shares the single SiTCP transmit FIFO write port (8-bit data, write-enable, programmable-full) between N_REQ byte-stream sources, e.g. TDC channel readout buffers. Each granted source sends one packet, framed with a 2-byte header and a 1-byte XOR trailer. The block sits in the 200 MHz system domain between the readout logic and the TCP TX FIFO. It aborts cleanly when the TCP connection drops.

---
 rtl/tcp_tx_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/tcp_tx_arbiter.sv | 172 +++++++++++++++++
 tb/tb_tcp_tx_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tcp_tx_pkg.sv
// Shared types and framing helpers for the TCP transmit packet scheduler.
package tcp_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEAD    = 3'd1,
        ST_SEQ     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_TRAIL   = 3'd4
    } tx_state_t;

    localparam logic [3:0] MAGIC_DEFAULT = 4'hA;
    localparam logic [7:0] CSUM_INIT     = 8'h00;

    // Header byte 0: magic nibble in [7:4], source id nibble in [3:0].
    function automatic logic [7:0] hdr_byte0(input logic [3:0] magic, input logic [3:0] id);
        return {magic, id};
    endfunction

    function automatic logic [7:0] csum_next(input logic [7:0] csum, input logic [7:0] data);
        return csum ^ data;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first requester at or after (prev_grant + 1) mod N_REQ,
// or from source 0 when no grant has been issued since reset.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [3:0]       prev_grant,
    input  logic             prev_valid,
    output logic [3:0]       grant_idx,
    output logic             grant_valid
);

    localparam logic [4:0] N_W = 5'(N_REQ);

    logic [15:0] req_ext_s;
    logic [4:0]  start_s;
    logic [4:0]  cand_s;

    // Rotating priority search from the start pointer
    always_comb begin
        req_ext_s   = 16'(req);
        grant_idx   = 4'd0;
        grant_valid = 1'b0;
        cand_s      = 5'd0;
        if (prev_valid && (({1'b0, prev_grant} + 5'd1) < N_W)) begin
            start_s = {1'b0, prev_grant} + 5'd1;
        end else begin
            start_s = 5'd0;
        end
        for (int k = 0; k < N_REQ; k++) begin
            cand_s = start_s + 5'(k);
            if (cand_s >= N_W) begin
                cand_s = cand_s - N_W;
            end else begin
                cand_s = cand_s;
            end
            if (!grant_valid && req_ext_s[cand_s[3:0]]) begin
                grant_idx   = cand_s[3:0];
                grant_valid = 1'b1;
            end else begin
                grant_valid = grant_valid;
            end
        end
    end

endmodule

// File: rtl/tcp_tx_arbiter.sv
// Round-robin packet scheduler sharing the SiTCP TX FIFO write port between N_REQ byte sources.
// Each packet is framed as {MAGIC,id}, seq, payload..., xor-checksum.
module tcp_tx_arbiter
    import tcp_tx_pkg::*;
#(
    parameter int         N_REQ = 4,
    parameter logic [3:0] MAGIC = MAGIC_DEFAULT
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               TCP_OPEN,
    input  logic               FIFO_FULL,
    input  logic [N_REQ-1:0]   REQ_VALID,
    input  logic [8*N_REQ-1:0] REQ_DATA,
    input  logic [N_REQ-1:0]   REQ_LAST,
    output logic [N_REQ-1:0]   REQ_READY,
    output logic [7:0]         TX_DATA,
    output logic               TX_EN,
    output logic [3:0]         GRANT_ID,
    output logic               BUSY,
    output logic               ABORT
);

    tx_state_t  state_r, state_nxt_s;
    logic [3:0] grant_id_r;
    logic       grant_seen_r;
    logic [7:0] pkt_seq_r;
    logic [7:0] csum_r, csum_nxt_s;
    logic [7:0] tx_data_r, wr_data_s;
    logic       tx_en_r, wr_en_s;
    logic       abort_r, abort_s;
    logic       seq_inc_s, grant_load_s;
    logic [3:0] arb_idx_s;
    logic       arb_valid_s;
    logic       sel_valid_s, sel_last_s;
    logic [7:0] sel_data_s;
    logic       xfer_ok_s, xfer_s;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req        (REQ_VALID),
        .prev_grant (grant_id_r),
        .prev_valid (grant_seen_r),
        .grant_idx  (arb_idx_s),
        .grant_valid(arb_valid_s)
    );

    // Select the granted source's stream and drive its ready; ready is held low during reset
    always_comb begin
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        sel_data_s  = 8'h00;
        REQ_READY   = '0;
        xfer_ok_s   = (state_r == ST_PAYLOAD) && TCP_OPEN && !FIFO_FULL && !RST;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id_r == 4'(i)) begin
                sel_valid_s  = REQ_VALID[i];
                sel_last_s   = REQ_LAST[i];
                sel_data_s   = REQ_DATA[8*i +: 8];
                REQ_READY[i] = xfer_ok_s;
            end else begin
                REQ_READY[i] = 1'b0;
            end
        end
        xfer_s = xfer_ok_s && sel_valid_s;
    end

    // Next-state and write decision; a dropped connection overrides everything else
    always_comb begin
        state_nxt_s  = state_r;
        wr_en_s      = 1'b0;
        wr_data_s    = 8'h00;
        csum_nxt_s   = csum_r;
        seq_inc_s    = 1'b0;
        grant_load_s = 1'b0;
        abort_s      = 1'b0;
        if ((state_r != ST_IDLE) && !TCP_OPEN) begin
            abort_s     = 1'b1;
            csum_nxt_s  = CSUM_INIT;
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (TCP_OPEN && arb_valid_s) begin
                        grant_load_s = 1'b1;
                        state_nxt_s  = ST_HEAD;
                    end else begin
                        state_nxt_s  = ST_IDLE;
                    end
                end
                ST_HEAD: begin
                    if (!FIFO_FULL) begin
                        wr_en_s     = 1'b1;
                        wr_data_s   = hdr_byte0(MAGIC, grant_id_r);
                        state_nxt_s = ST_SEQ;
                    end else begin
                        state_nxt_s = ST_HEAD;
                    end
                end
                ST_SEQ: begin
                    if (!FIFO_FULL) begin
                        wr_en_s     = 1'b1;
                        wr_data_s   = pkt_seq_r;
                        state_nxt_s = ST_PAYLOAD;
                    end else begin
                        state_nxt_s = ST_SEQ;
                    end
                end
                ST_PAYLOAD: begin
                    if (xfer_s) begin
                        wr_en_s     = 1'b1;
                        wr_data_s   = sel_data_s;
                        csum_nxt_s  = csum_next(csum_r, sel_data_s);
                        state_nxt_s = sel_last_s ? ST_TRAIL : ST_PAYLOAD;
                    end else begin
                        state_nxt_s = ST_PAYLOAD;
                    end
                end
                ST_TRAIL: begin
                    if (!FIFO_FULL) begin
                        wr_en_s     = 1'b1;
                        wr_data_s   = csum_r;
                        csum_nxt_s  = CSUM_INIT;
                        seq_inc_s   = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_TRAIL;
                    end
                end
                default: begin
                    csum_nxt_s  = CSUM_INIT;
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, grant pointer, counters and the FIFO-side output register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= ST_IDLE;
            grant_id_r   <= 4'd0;
            grant_seen_r <= 1'b0;
            pkt_seq_r    <= 8'h00;
            csum_r       <= CSUM_INIT;
            tx_data_r    <= 8'h00;
            tx_en_r      <= 1'b0;
            abort_r      <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            csum_r  <= csum_nxt_s;
            tx_en_r <= wr_en_s;
            abort_r <= abort_s;
            if (wr_en_s) begin
                tx_data_r <= wr_data_s;
            end
            if (seq_inc_s) begin
                pkt_seq_r <= pkt_seq_r + 8'd1;
            end
            if (grant_load_s) begin
                grant_id_r   <= arb_idx_s;
                grant_seen_r <= 1'b1;
            end
        end
    end

    assign TX_DATA  = tx_data_r;
    assign TX_EN    = tx_en_r;
    assign GRANT_ID = grant_id_r;
    assign ABORT    = abort_r;
    assign BUSY     = (state_r != ST_IDLE);

endmodule

// File: tb/tb_tcp_tx_arbiter.sv
// Directed bench for tcp_tx_arbiter: source queues feed the DUT, a monitor records FIFO writes,
// and each step compares against hand-computed byte streams.
`timescale 1ns/1ps
module tb_tcp_tx_arbiter;

    localparam int N = 4;

    logic           CLK = 1'b0;
    logic           RST;
    logic           TCP_OPEN;
    logic           FIFO_FULL;
    logic [N-1:0]   REQ_VALID;
    logic [8*N-1:0] REQ_DATA;
    logic [N-1:0]   REQ_LAST;
    logic [N-1:0]   REQ_READY;
    logic [7:0]     TX_DATA;
    logic           TX_EN;
    logic [3:0]     GRANT_ID;
    logic           BUSY;
    logic           ABORT;

    logic [8:0] src_q [N][$];
    logic [7:0] txq [$];
    int         cycq [$];
    logic [7:0] expq [$];
    int         cyc   = 0;
    int         total = 0;
    int         bad   = 0;

    tcp_tx_arbiter #(.N_REQ(N), .MAGIC(4'hA)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .TCP_OPEN (TCP_OPEN),
        .FIFO_FULL(FIFO_FULL),
        .REQ_VALID(REQ_VALID),
        .REQ_DATA (REQ_DATA),
        .REQ_LAST (REQ_LAST),
        .REQ_READY(REQ_READY),
        .TX_DATA  (TX_DATA),
        .TX_EN    (TX_EN),
        .GRANT_ID (GRANT_ID),
        .BUSY     (BUSY),
        .ABORT    (ABORT)
    );

    always #2.5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Sources: present queue heads on the falling edge, retire on accepted rising edge
    always @(negedge CLK) begin
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                REQ_VALID[i]      = 1'b1;
                REQ_DATA[8*i +: 8] = src_q[i][0][7:0];
                REQ_LAST[i]       = src_q[i][0][8];
            end else begin
                REQ_VALID[i]      = 1'b0;
                REQ_DATA[8*i +: 8] = 8'h00;
                REQ_LAST[i]       = 1'b0;
            end
        end
    end

    always @(posedge CLK) begin
        for (int i = 0; i < N; i++) begin
            if (REQ_VALID[i] === 1'b1 && REQ_READY[i] === 1'b1 && src_q[i].size() > 0)
                void'(src_q[i].pop_front());
        end
    end

    // FIFO write monitor
    always @(negedge CLK) begin
        if (TX_EN === 1'b1) begin
            txq.push_back(TX_DATA);
            cycq.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] txb(input int i);
        if (i < txq.size()) return {24'h0, txq[i]};
        return 32'hFFFF_FFFF;
    endfunction

    function automatic bit src_empty();
        for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_pkt(input int src, input int n, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
        logic [7:0] b [5];
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3; b[4] = b4;
        for (int i = 0; i < n; i++) src_q[src].push_back({(i == n - 1) ? 1'b1 : 1'b0, b[i]});
    endtask

    task automatic ex(input int n, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                      input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                      input logic [7:0] b6, input logic [7:0] b7);
        logic [7:0] b [8];
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3; b[4] = b4; b[5] = b5; b[6] = b6; b[7] = b7;
        for (int i = 0; i < n; i++) expq.push_back(b[i]);
    endtask

    task automatic chk_stream(input string tag);
        chk({tag, "_len"}, txq.size(), expq.size());
        for (int i = 0; i < expq.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), txb(i), {24'h0, expq[i]});
        txq.delete();
        cycq.delete();
        expq.delete();
    endtask

    task automatic wait_done(input string tag, input int budget);
        logic done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge CLK); #1;
            if (src_empty() && BUSY === 1'b0) done = 1'b1;
        end
        @(negedge CLK); #1;
        chk({tag, "_done"}, done, 1'b1);
    endtask

    task automatic wait_len(input string tag, input int n, input int budget);
        logic done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge CLK); #1;
            if (txq.size() >= n) done = 1'b1;
        end
        chk({tag, "_reach"}, done, 1'b1);
    endtask

    initial begin
        RST = 1'b1; TCP_OPEN = 1'b0; FIFO_FULL = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_ready", REQ_READY, 4'b0000);
        chk("rst_txen", TX_EN, 1'b0);
        chk("rst_txdata", TX_DATA, 8'h00);
        chk("rst_grant", GRANT_ID, 4'd0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_abort", ABORT, 1'b0);
        RST = 1'b0;
        @(negedge CLK);

        // Round-robin from a fresh reset: 0,1,2 then back to 0
        TCP_OPEN = 1'b1;
        push_pkt(0, 1, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00);
        push_pkt(1, 1, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00);
        push_pkt(2, 1, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00);
        push_pkt(0, 1, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00);
        wait_done("rr", 200);
        ex(8, 8'hA0, 8'h00, 8'h05, 8'h05, 8'hA1, 8'h01, 8'h06, 8'h06);
        ex(8, 8'hA2, 8'h02, 8'h07, 8'h07, 8'hA0, 8'h03, 8'h09, 8'h09);
        chk_stream("rr");
        chk("rr_grant", GRANT_ID, 4'd0);

        // Single source, 3 bytes, back-to-back writes
        push_pkt(0, 3, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00);
        wait_done("single", 100);
        for (int i = 1; i < 6; i++)
            chk($sformatf("single_gap%0d", i), cycq.size() > i ? cycq[i] - cycq[i-1] : -1, 1);
        ex(6, 8'hA0, 8'h04, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00);
        chk_stream("single");

        // Backpressure: FIFO_FULL for 4 cycles after two payload bytes
        push_pkt(1, 5, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10);
        wait_len("bp", 4, 100);
        FIFO_FULL = 1'b1;
        #1;
        chk("bp_ready0", REQ_READY, 4'b0000);
        for (int k = 1; k <= 4; k++) begin
            @(negedge CLK); #1;
            chk($sformatf("bp_txen%0d", k), TX_EN, 1'b0);
            if (k < 4) chk($sformatf("bp_ready%0d", k), REQ_READY, 4'b0000);
        end
        FIFO_FULL = 1'b0;
        #1;
        chk("bp_ready_rel", REQ_READY, 4'b0010);
        @(negedge CLK); #1;
        chk("bp_txen_rel", TX_EN, 1'b1);
        wait_done("bp", 100);
        ex(8, 8'hA1, 8'h05, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h1F);
        chk_stream("bp");

        // Abort after two of five payload bytes
        push_pkt(2, 5, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25);
        wait_len("ab", 4, 100);
        TCP_OPEN = 1'b0;
        src_q[2].delete();
        #1;
        chk("ab_ready", REQ_READY, 4'b0000);
        @(negedge CLK); #1;
        chk("ab_pulse", ABORT, 1'b1);
        chk("ab_busy", BUSY, 1'b0);
        chk("ab_txen", TX_EN, 1'b0);
        @(negedge CLK); #1;
        chk("ab_pulse_end", ABORT, 1'b0);
        ex(4, 8'hA2, 8'h06, 8'h21, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00);
        chk_stream("ab");
        TCP_OPEN = 1'b1;
        push_pkt(3, 1, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00);
        wait_done("ab_next", 100);
        ex(4, 8'hA3, 8'h06, 8'h33, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00);
        chk_stream("ab_next");
        chk("ab_grant", GRANT_ID, 4'd3);

        // 256 packets of FF,0F: trailer F0, sequence wraps through FF -> 00
        for (int p = 0; p < 256; p++) push_pkt(0, 2, 8'hFF, 8'h0F, 8'h00, 8'h00, 8'h00);
        wait_done("wrap", 4000);
        chk("wrap_ff", txb(1241), 32'h0000_00FF);
        chk("wrap_00", txb(1246), 32'h0000_0000);
        for (int p = 0; p < 256; p++) ex(5, 8'hA0, 8'(7 + p), 8'hFF, 8'h0F, 8'hF0, 8'h00, 8'h00, 8'h00);
        chk_stream("wrap");

        // Reset mid-payload: outputs to reset values, sequence and arbitration restart
        push_pkt(0, 5, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45);
        wait_len("rs", 4, 100);
        RST = 1'b1;
        src_q[0].delete();
        #1;
        chk("rs_ready_in", REQ_READY, 4'b0000);
        @(negedge CLK); #1;
        chk("rs_txen", TX_EN, 1'b0);
        chk("rs_txdata", TX_DATA, 8'h00);
        chk("rs_grant", GRANT_ID, 4'd0);
        chk("rs_busy", BUSY, 1'b0);
        chk("rs_abort", ABORT, 1'b0);
        chk("rs_ready", REQ_READY, 4'b0000);
        RST = 1'b0;
        ex(4, 8'hA0, 8'h07, 8'h41, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00);
        chk_stream("rs_cut");
        push_pkt(0, 1, 8'h51, 8'h00, 8'h00, 8'h00, 8'h00);
        push_pkt(1, 1, 8'h52, 8'h00, 8'h00, 8'h00, 8'h00);
        wait_done("rs_after", 100);
        ex(8, 8'hA0, 8'h00, 8'h51, 8'h51, 8'hA1, 8'h01, 8'h52, 8'h52);
        chk_stream("rs_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
